// File: rtl/ks_adder_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder: the per-bit
// generate/propagate pair, a ceiling-log2 helper and the function that
// decides which prefix levels belong to which register slice.
package ks_adder_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // Ceiling log2, usable in constant expressions
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem = rem >> 1;
      end
      return result;
   endfunction

   // First prefix level handled by a given slice. Slice s owns levels
   // [stage_first_level(s), stage_first_level(s+1)), which spreads the
   // levels as evenly as possible; the trailing slice may own none.
   function automatic int stage_first_level(input int stage, input int levels,
                                            input int stages);
      return (stage * levels + stages - 1) / stages;
   endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level: each bit at or above DIST
// merges its group with the group DIST positions below; lower bits pass
// through unchanged because their groups already reach bit 0.
module ks_prefix_level
   import ks_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  gp_t [WIDTH-1:0] gp_in,
   output gp_t [WIDTH-1:0] gp_out
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= DIST) begin : g_merge
         assign gp_out[i].g = gp_in[i].g | (gp_in[i].p & gp_in[i-DIST].g);
         assign gp_out[i].p = gp_in[i].p & gp_in[i-DIST].p;
      end else begin : g_pass
         assign gp_out[i] = gp_in[i];
      end
   end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready handshaking.
// The carry-in is folded into bit 0's generate so the prefix tree yields
// the true carry out of every bit; the log2(WIDTH) prefix levels are spread
// over STAGES register slices, the last of which is the output register.
// Optional feature: define KS_ADDER_PIPE_SUB_EN to add a 'sub' input that
// selects a - b (a + ~b + 1) instead of a + b + cin.
module ks_adder_pipe
   import ks_adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef KS_ADDER_PIPE_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int LEVELS = clog2(WIDTH);
   localparam int NREG   = (STAGES > 1) ? STAGES - 1 : 1;

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [WIDTH-1:0] p_init;
   gp_t [WIDTH-1:0]  gp_init;

   // Segment boundaries: inputs to and results of each slice's logic
   gp_t [WIDTH-1:0]  seg_in  [STAGES];
   gp_t [WIDTH-1:0]  seg_out [STAGES];
   logic [WIDTH-1:0] p0_in   [STAGES];
   logic             cin_in  [STAGES];
   logic             vld_in  [STAGES];
   gp_t [WIDTH-1:0]  lvl_out [LEVELS];

   // Inter-slice registers (all slices except the output slice)
   gp_t [WIDTH-1:0]  gp_q  [NREG];
   logic [WIDTH-1:0] p0_q  [NREG];
   logic             cin_q [NREG];
   logic             vld_q [NREG];

   logic [WIDTH-1:0] grp_g;
   logic [WIDTH-1:0] unused_grp_p;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             ovf_d;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Condition the operands and form per-bit generate/propagate, with the
   // carry-in merged into bit 0 so every group generate is a real carry
   always_comb begin
`ifdef KS_ADDER_PIPE_SUB_EN
      b_eff   = sub ? ~b : b;
      cin_eff = sub ? 1'b1 : cin;
`else
      b_eff   = b;
      cin_eff = cin;
`endif
      p_init = a ^ b_eff;
      for (int i = 0; i < WIDTH; i++) begin
         gp_init[i].g = a[i] & b_eff[i];
         gp_init[i].p = p_init[i];
      end
      gp_init[0].g = (a[0] & b_eff[0]) | (p_init[0] & cin_eff);
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_seg
      localparam int LO = stage_first_level(s, LEVELS, STAGES);
      localparam int HI = stage_first_level(s + 1, LEVELS, STAGES);

      if (s == 0) begin : g_head
         assign seg_in[s] = gp_init;
         assign p0_in[s]  = p_init;
         assign cin_in[s] = cin_eff;
         assign vld_in[s] = in_valid;
      end else begin : g_head
         assign seg_in[s] = gp_q[s-1];
         assign p0_in[s]  = p0_q[s-1];
         assign cin_in[s] = cin_q[s-1];
         assign vld_in[s] = vld_q[s-1];
      end

      for (genvar l = LO; l < HI; l++) begin : g_lvl
         if (l == LO) begin : g_first
            ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << l)) u_level (
               .gp_in  (seg_in[s]),
               .gp_out (lvl_out[l])
            );
         end else begin : g_chain
            ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << l)) u_level (
               .gp_in  (lvl_out[l-1]),
               .gp_out (lvl_out[l])
            );
         end
      end

      if (HI == LO) begin : g_empty
         assign seg_out[s] = seg_in[s];
      end else begin : g_tail
         assign seg_out[s] = lvl_out[HI-1];
      end
   end

   // Inter-slice registers advance together, valid bits included, so bubbles
   // keep their position and a stall freezes the whole pipe
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < STAGES - 1; s++) begin
            vld_q[s] <= 1'b0;
            gp_q[s]  <= '0;
            p0_q[s]  <= '0;
            cin_q[s] <= 1'b0;
         end
      end else if (adv) begin
         for (int s = 0; s < STAGES - 1; s++) begin
            vld_q[s] <= vld_in[s];
            gp_q[s]  <= seg_out[s];
            p0_q[s]  <= p0_in[s];
            cin_q[s] <= cin_in[s];
         end
      end
   end

   // Final carries give sum, unsigned carry-out and signed overflow
   // (carry into the MSB differs from carry out of it)
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         grp_g[i]        = seg_out[STAGES-1][i].g;
         unused_grp_p[i] = seg_out[STAGES-1][i].p;
      end
      sum_d  = p0_in[STAGES-1] ^ {grp_g[WIDTH-2:0], cin_in[STAGES-1]};
      cout_d = grp_g[WIDTH-1];
      ovf_d  = grp_g[WIDTH-1] ^ grp_g[WIDTH-2];
   end

   // Output slice: registered result and valid, held while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (adv) begin
         out_valid <= vld_in[STAGES-1];
         sum       <= sum_d;
         cout      <= cout_d;
         ovf       <= ovf_d;
      end
   end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Directed testbench for ks_adder_pipe (WIDTH=32, STAGES=2): reset state,
// hand-computed vectors, back-to-back traffic, stall, mid-flight reset and,
// when KS_ADDER_PIPE_SUB_EN is defined, subtraction.
module tb_ks_adder_pipe;

   localparam int WIDTH  = 32;
   localparam int STAGES = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             subSel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int gotCount   = 0;
   logic [33:0] expQ[$];

   ks_adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef KS_ADDER_PIPE_SUB_EN
      .sub       (subSel),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Safety net against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference result {cout, ovf, sum} from plain wide arithmetic
   function automatic logic [33:0] modelAdd(input logic [31:0] x, input logic [31:0] y,
                                            input logic c, input logic s);
      logic [31:0] yy;
      logic        cc;
      logic [32:0] full;
      logic        v;
      yy   = s ? ~y : y;
      cc   = s ? 1'b1 : c;
      full = {1'b0, x} + {1'b0, yy} + {32'd0, cc};
      v    = (x[31] == yy[31]) && (full[31] != x[31]);
      return {full[32], v, full[31:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] x, input logic [31:0] y,
                                input logic c);
      in_valid = v;
      a        = x;
      b        = y;
      cin      = c;
   endtask

   // One clock with scoreboard bookkeeping for the handshakes at this edge
   task automatic doCycle(input string tag);
      logic [33:0] expv;
      if (out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 64'd0, 64'd1);
         end else begin
            expv = expQ.pop_front();
            checkOutput(tag, {30'd0, cout, ovf, sum}, {30'd0, expv});
            gotCount++;
         end
      end
      if (in_valid && in_ready) expQ.push_back(modelAdd(a, b, cin, subSel));
      tick();
   endtask

   // Single isolated operation with hand-computed result and exact latency
   task automatic runOne(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic [31:0] eSum, input logic eCout,
                         input logic eOvf);
      applyStimulus(1'b1, x, y, c);
      checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      tick();
      checkOutput({tag, "_early"}, 64'(out_valid), 64'd0);
      in_valid = 1'b0;
      tick();
      checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
      checkOutput(tag, {30'd0, cout, ovf, sum}, {30'd0, eCout, eOvf, eSum});
      tick();
      checkOutput({tag, "_drained"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int gapCount;
      int notReady;

      subSel    = 1'b0;
      out_ready = 1'b1;
      rst       = 1'b1;
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
      tick();
      tick();
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_result", {30'd0, cout, ovf, sum}, 64'd0);
      rst = 1'b0;
      tick();
      checkOutput("ready_after_reset", 64'(in_ready), 64'd1);

      $display("[TB] directed vectors");
      runOne("add_3_1",     32'd3,         32'd1,         1'b0, 32'd4,         1'b0, 1'b0);
      runOne("add_ffff_c1", 32'hFFFFFFFF,  32'd0,         1'b1, 32'd0,         1'b1, 1'b0);
      runOne("add_pos_ovf", 32'h7FFFFFFF,  32'd1,         1'b0, 32'h80000000,  1'b0, 1'b1);
      runOne("add_neg_ovf", 32'h80000000,  32'h80000000,  1'b0, 32'd0,         1'b1, 1'b1);
      runOne("add_all_one", 32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'hFFFFFFFF,  1'b1, 1'b0);
      runOne("add_mixed",   32'h12345678,  32'h9ABCDEF0,  1'b0, 32'hACF13568,  1'b0, 1'b0);
      runOne("add_ripple",  32'hAAAAAAAA,  32'h55555555,  1'b1, 32'd0,         1'b1, 1'b0);

      $display("[TB] back-to-back random traffic");
      gotCount = 0;
      gapCount = 0;
      notReady = 0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
         if (!in_ready) notReady++;
         doCycle("b2b");
         if (i >= STAGES - 1 && !out_valid) gapCount++;
      end
      in_valid = 1'b0;
      for (int n = 0; n < 20 && expQ.size() > 0; n++) doCycle("b2b");
      checkOutput("b2b_count", 64'(gotCount), 64'd100);
      checkOutput("b2b_gaps", 64'(gapCount), 64'd0);
      checkOutput("b2b_ready", 64'(notReady), 64'd0);
      checkOutput("b2b_empty", 64'(expQ.size()), 64'd0);

      $display("[TB] stall with full pipeline");
      out_ready = 1'b0;
      for (int n = 0; n < 10 && !out_valid; n++) begin
         applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
         doCycle("stall_fill");
      end
      checkOutput("stall_fill_valid", 64'(out_valid), 64'd1);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
         doCycle("stall");
         checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
         if (expQ.size() == 0) checkOutput("stall_queue", 64'd0, 64'd1);
         else checkOutput("stall_hold", {29'd0, out_valid, cout, ovf, sum},
                          {29'd0, 1'b1, expQ[0]});
      end
      gotCount  = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 20 && expQ.size() > 0; n++) doCycle("stall_drain");
      checkOutput("stall_drain_count", 64'(gotCount), 64'(STAGES));
      checkOutput("stall_drain_empty", 64'(expQ.size()), 64'd0);
      checkOutput("stall_drain_idle", 64'(out_valid), 64'd0);

      $display("[TB] reset with operations in flight");
      applyStimulus(1'b1, 32'h11111111, 32'h22222222, 1'b0);
      doCycle("flight");
      applyStimulus(1'b1, 32'h33333333, 32'h44444444, 1'b1);
      doCycle("flight");
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midreset_sum", 64'(sum), 64'd0);
      expQ.delete();
      rst = 1'b0;
      tick();
      checkOutput("midreset_ready", 64'(in_ready), 64'd1);
      runOne("after_reset", 32'd10, 32'd5, 1'b0, 32'd15, 1'b0, 1'b0);

`ifdef KS_ADDER_PIPE_SUB_EN
      $display("[TB] subtraction");
      subSel = 1'b1;
      runOne("sub_5_7",   32'd5,        32'd7, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
      runOne("sub_7_5",   32'd7,        32'd5, 1'b1, 32'd2,        1'b1, 1'b0);
      runOne("sub_ovf",   32'h80000000, 32'd1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
      subSel = 1'b0;
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
